// File: rtl/io_pkg.sv
// Shared types and defaults for the CPU OUT write buffer.
package io_pkg;
  localparam int IO_ADDR_W         = 16;
  localparam int IO_DATA_W         = 16;
  localparam int IO_DEPTH_DEF      = 4;
  localparam int IO_PORT_COUNT_DEF = 4;

  typedef struct packed {
    logic [IO_ADDR_W-1:0] addr;
    logic [IO_DATA_W-1:0] data;
  } io_wr_t;
endpackage

// File: rtl/io_fifo.sv
// Write-entry FIFO: storage, wrapping pointers, occupancy, registered valid/full.
module io_fifo
  import io_pkg::*;
#(
  parameter int DEPTH = IO_DEPTH_DEF
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  logic   pop,
  input  io_wr_t wr_entry,
  output io_wr_t head,
  output logic   valid,
  output logic   full
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  io_wr_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_nxt;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // DEPTH is a power of two, so the pointer increments wrap on their own.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      full   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      valid <= (count_nxt != '0);
      full  <= (count_nxt == CNT_W'(DEPTH));
    end
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/io_write_buffer.sv
// CPU OUT write buffer with peripheral handshake, sticky overflow and
// optional port shadow readback (enabled by defining IO_SHADOW_EN).
module io_write_buffer
  import io_pkg::*;
#(
  parameter int DEPTH      = IO_DEPTH_DEF,
  parameter int PORT_COUNT = IO_PORT_COUNT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_strobe,
  input  logic [IO_ADDR_W-1:0] wr_addr,
  input  logic [IO_DATA_W-1:0] wr_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IO_ADDR_W-1:0] out_addr,
  output logic [IO_DATA_W-1:0] out_data,
  output logic                 full,
  output logic                 overflow,
  input  logic [IO_ADDR_W-1:0] rd_addr,
  output logic [IO_DATA_W-1:0] rd_data
);
  io_wr_t wr_entry, head;
  logic   push, pop;

  assign pop      = out_valid & out_ready;
  // A full buffer still accepts a write when the head leaves in the same cycle.
  assign push     = wr_strobe & (~full | pop);
  assign wr_entry = '{addr: wr_addr, data: wr_data};

  io_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .wr_entry (wr_entry),
    .head     (head),
    .valid    (out_valid),
    .full     (full)
  );

  assign out_addr = head.addr;
  assign out_data = head.data;

  always_ff @(posedge clk) begin
    if (reset)                         overflow <= 1'b0;
    else if (wr_strobe & full & ~pop)  overflow <= 1'b1;
  end

`ifdef IO_SHADOW_EN
  logic [PORT_COUNT-1:0][IO_DATA_W-1:0] shadow;

  // Readback samples the pre-update shadow, so a same-cycle pop shows next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow  <= '0;
      rd_data <= '0;
    end else begin
      rd_data <= '0;
      for (int k = 0; k < PORT_COUNT; k++) begin
        if (pop && out_addr == IO_ADDR_W'(k)) shadow[k] <= out_data;
        if (rd_addr == IO_ADDR_W'(k))         rd_data   <= shadow[k];
      end
    end
  end
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^rd_addr;
  assign rd_data        = '0;
`endif
endmodule

// File: tb/tb_io_write_buffer.sv
// Directed self-checking bench for io_write_buffer (default DEPTH=4, PORT_COUNT=4).
module tb_io_write_buffer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_strobe = 1'b0;
  logic [15:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_addr;
  logic [15:0] out_data;
  logic        full;
  logic        overflow;
  logic [15:0] rd_addr = '0;
  logic [15:0] rd_data;

  int vecs = 0;
  int errs = 0;

  io_write_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .full      (full),
    .overflow  (overflow),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  initial begin
    // reset state
    step(); step();
    chk("rst_valid", 16'(out_valid), 16'd0);
    chk("rst_full",  16'(full),      16'd0);
    chk("rst_ovf",   16'(overflow),  16'd0);
    chk("rst_addr",  out_addr,       16'd0);
    chk("rst_data",  out_data,       16'd0);
    chk("rst_rd",    rd_data,        16'd0);
    reset = 1'b0;
    step();
    chk("idle_valid", 16'(out_valid), 16'd0);

    // single write, one-cycle latency, one-cycle presentation
    wr_strobe = 1'b1; wr_addr = 16'd1; wr_data = 16'h000A; out_ready = 1'b1;
    step();
    wr_strobe = 1'b0;
    chk("single_valid", 16'(out_valid), 16'd1);
    chk("single_addr",  out_addr,       16'd1);
    chk("single_data",  out_data,       16'h000A);
    step();
    chk("single_gone",  16'(out_valid), 16'd0);

    // backpressure, fifth write dropped
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      wr_strobe = 1'b1; wr_addr = 16'h0020; wr_data = 16'(i);
      step();
      if (i == 3) chk("bp_notfull3", 16'(full), 16'd0);
      if (i == 4) begin
        chk("bp_full4", 16'(full),     16'd1);
        chk("bp_ovf4",  16'(overflow), 16'd0);
      end
    end
    wr_strobe = 1'b0;
    chk("bp_full5", 16'(full),     16'd1);
    chk("bp_ovf5",  16'(overflow), 16'd1);
    step();
    chk("bp_hold_data", out_data, 16'd1);
    chk("bp_hold_addr", out_addr, 16'h0020);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("bp_drain_valid", 16'(out_valid), 16'd1);
      chk("bp_drain_data",  out_data,       16'(i));
      step();
    end
    chk("bp_no5",      16'(out_valid), 16'd0);
    chk("bp_ovf_stky", 16'(overflow),  16'd1);

    // clear overflow, then full with simultaneous push and pop
    reset = 1'b1; out_ready = 1'b0;
    step();
    reset = 1'b0;
    chk("rst2_ovf", 16'(overflow), 16'd0);
    for (int i = 1; i <= 4; i++) begin
      wr_strobe = 1'b1; wr_addr = 16'd3; wr_data = 16'(i);
      step();
    end
    chk("pp_full_before", 16'(full), 16'd1);
    wr_data = 16'h0055; out_ready = 1'b1;
    step();
    wr_strobe = 1'b0; out_ready = 1'b0;
    chk("pp_full_after", 16'(full),     16'd1);
    chk("pp_ovf",        16'(overflow), 16'd0);
    chk("pp_head",       out_data,      16'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("pp_drain", out_data, (i == 3) ? 16'h0055 : 16'(i + 2));
      step();
    end
    chk("pp_empty", 16'(out_valid), 16'd0);

`ifdef IO_SHADOW_EN
    // readback of port 2, out-of-range port, ignored high address
    wr_strobe = 1'b1; wr_addr = 16'd2; wr_data = 16'hBEEF;
    step();
    wr_strobe = 1'b0;
    step();
    rd_addr = 16'd2; step();
    chk("rb_p2", rd_data, 16'hBEEF);
    rd_addr = 16'd7; step();
    chk("rb_p7", rd_data, 16'd0);
    rd_addr = 16'd3; step();
    chk("rb_p3", rd_data, 16'h0055);
    wr_strobe = 1'b1; wr_addr = 16'd9; wr_data = 16'h1234;
    step();
    wr_strobe = 1'b0;
    step();
    rd_addr = 16'd2; step();
    chk("rb_p2_after9", rd_data, 16'hBEEF);
    rd_addr = 16'd0; step();
    chk("rb_p0_after9", rd_data, 16'd0);
    // same-cycle pop and read of port 2: old then new
    wr_strobe = 1'b1; wr_addr = 16'd2; wr_data = 16'hCAFE; rd_addr = 16'd2;
    step();
    wr_strobe = 1'b0;
    step();
    chk("rb_same_old", rd_data, 16'hBEEF);
    step();
    chk("rb_same_new", rd_data, 16'hCAFE);
`else
    for (int i = 0; i < 3; i++) begin
      wr_strobe = 1'b1; wr_addr = 16'(i); wr_data = 16'hA5A0 + 16'(i); rd_addr = 16'(i);
      step();
      wr_strobe = 1'b0;
      step(); step();
      chk("noshadow_rd", rd_data, 16'd0);
    end
`endif

    // reset mid-run with a strobe during reset
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_strobe = 1'b1; wr_addr = 16'd1; wr_data = 16'h0100 + 16'(i);
      step();
    end
    chk("mid_valid_before", 16'(out_valid), 16'd1);
    reset = 1'b1; wr_data = 16'h0BAD;
    step();
    reset = 1'b0; wr_strobe = 1'b0;
    chk("mid_valid", 16'(out_valid), 16'd0);
    chk("mid_full",  16'(full),      16'd0);
    chk("mid_ovf",   16'(overflow),  16'd0);
    chk("mid_rd",    rd_data,        16'd0);
    step();
    chk("mid_strobe_ignored", 16'(out_valid), 16'd0);
    wr_strobe = 1'b1; wr_addr = 16'd5; wr_data = 16'h0077; out_ready = 1'b1;
    step();
    wr_strobe = 1'b0;
    chk("post_valid", 16'(out_valid), 16'd1);
    chk("post_addr",  out_addr,       16'd5);
    chk("post_data",  out_data,       16'h0077);
    step();
    chk("post_gone",  16'(out_valid), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
